// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - opcodes, class/state enums and Ctrl strobe bit map for the Mini SRC sequencer
package ctrl_seq_pkg;

    // Opcodes occupy IR[31:27]; every code from 5'b00000 to 5'b11010 is defined
    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
    } cls_t;

    typedef enum logic [2:0] {
        S_RST, S_F0, S_F1, S_F2, S_DEC, S_EXEC, S_PAUSE, S_HALT
    } state_t;

    // Ctrl strobe bit indices
    localparam int C_PCOUT  = 0,  C_MARIN  = 1,  C_MEMRD  = 2,  C_MDRIN     = 3;
    localparam int C_MDROUT = 4,  C_IRIN   = 5,  C_INCPC  = 6,  C_PCIN      = 7;
    localparam int C_GRA    = 8,  C_GRB    = 9,  C_GRC    = 10, C_ROUT      = 11;
    localparam int C_RIN    = 12, C_BAOUT  = 13, C_YIN    = 14, C_ZHIN      = 15;
    localparam int C_ZLIN   = 16, C_ZHOUT  = 17, C_ZLOUT  = 18, C_COUT      = 19;
    localparam int C_LOIN   = 20, C_HIIN   = 21, C_LOOUT  = 22, C_HIOUT     = 23;
    localparam int C_CONIN  = 24, C_PCINCOND = 25, C_INPORTOUT = 26, C_OUTPORTIN = 27;
    localparam int C_MEMWR  = 28;
    localparam int CW       = 29;

    function automatic logic [CW-1:0] cbit(input int idx);
        return {{(CW-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Final execute step of each class; the instruction boundary is taken when leaving it
    function automatic logic [2:0] last_step(input cls_t c);
        case (c)
            CL_ALU, CL_IMM, CL_LDI: return 3'd5;
            CL_MULDIV, CL_BR:       return 3'd6;
            CL_UNARY, CL_JAL:       return 3'd4;
            CL_LD, CL_ST:           return 3'd7;
            default:                return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// rtl/ctrl_seq_decode.sv - combinational opcode to instruction class and legality
// Ports: i_opcode (IR opcode field) -> o_cls (execute class), o_legal (opcode defined)
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] i_opcode,
    output cls_t           o_cls,
    output logic           o_legal
);

    always_comb begin
        o_cls   = CL_NOP;
        o_legal = 1'b1;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: o_cls = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       o_cls = CL_IMM;
            OP_MUL, OP_DIV:                 o_cls = CL_MULDIV;
            OP_NEG, OP_NOT:                 o_cls = CL_UNARY;
            OP_LD:                          o_cls = CL_LD;
            OP_LDI:                         o_cls = CL_LDI;
            OP_ST:                          o_cls = CL_ST;
            OP_BR:                          o_cls = CL_BR;
            OP_JR:                          o_cls = CL_JR;
            OP_JAL:                         o_cls = CL_JAL;
            OP_MFHI:                        o_cls = CL_MFHI;
            OP_MFLO:                        o_cls = CL_MFLO;
            OP_IN:                          o_cls = CL_IN;
            OP_OUT:                         o_cls = CL_OUT;
            OP_NOP:                         o_cls = CL_NOP;
            OP_HALT:                        o_cls = CL_HALT;
            default:                        o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq_param.sv
// rtl/ctrl_seq_param.sv - multicycle fetch/decode/execute control sequencer for the Mini SRC datapath
// Ports: Clock, Reset (async, high); IR, MemAck, Stop, StepEn, Step in;
//        Ctrl strobe word, R_enableIn (jal link), Run, Halted, BusErr (sticky), IllegalOp, InstrDone out
module ctrl_seq_param
    import ctrl_seq_pkg::*;
#(
    parameter int OPW      = 5,
    parameter int NREG     = 16,
    parameter int LINK_REG = 15,
    parameter int MEM_TO   = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [31:0]     IR,
    input  logic            MemAck,
    input  logic            Stop,
    input  logic            StepEn,
    input  logic            Step,
    output logic [CW-1:0]   Ctrl,
    output logic [NREG-1:0] R_enableIn,
    output logic            Run,
    output logic            Halted,
    output logic            BusErr,
    output logic            IllegalOp,
    output logic            InstrDone
);

    localparam int WCW = $clog2(MEM_TO + 1);
    localparam logic [NREG-1:0] LINK_MASK = {{(NREG-1){1'b0}}, 1'b1} << LINK_REG;

    state_t         r_state, w_nstate;
    logic [2:0]     r_tstep, w_ntstep;
    cls_t           r_cls, w_dcls;
    logic [WCW-1:0] r_wcnt, w_nwcnt;
    logic           r_buserr;
    logic           w_legal, w_waiting, w_last, w_timeout;
    logic           w_unused_ir;

    assign w_unused_ir = ^IR[31-OPW:0];

    ctrl_seq_decode #(.OPW(OPW)) u_decode (
        .i_opcode (IR[31:32-OPW]),
        .o_cls    (w_dcls),
        .o_legal  (w_legal)
    );

    // Memory wait states: instruction fetch read, ld T6 read, st T7 write
    assign w_waiting = (r_state == S_F1) ||
                       (r_state == S_EXEC && ((r_cls == CL_LD && r_tstep == 3'd6) ||
                                              (r_cls == CL_ST && r_tstep == 3'd7)));
    assign w_last    = (r_state == S_EXEC) && (r_tstep == last_step(r_cls));
    assign w_timeout = w_waiting && !MemAck && (r_wcnt == WCW'(MEM_TO - 1));

    always_comb begin
        w_nstate = r_state;
        w_ntstep = r_tstep;
        w_nwcnt  = '0;      // counter clears on every exit so each wait starts at 0
        if (w_waiting && !MemAck) begin
            if (w_timeout) w_nstate = S_HALT;
            else           w_nwcnt  = r_wcnt + 1'b1;
        end else begin
            case (r_state)
                S_RST:  w_nstate = S_F0;
                S_F0:   w_nstate = S_F1;
                S_F1:   w_nstate = S_F2;
                S_F2:   w_nstate = S_DEC;
                S_DEC: begin
                    if (!w_legal)               w_nstate = S_F0;
                    else if (w_dcls == CL_HALT) w_nstate = S_HALT;
                    else begin
                        w_nstate = S_EXEC;
                        w_ntstep = 3'd3;
                    end
                end
                S_EXEC: begin
                    if (w_last) w_nstate = (Stop || StepEn) ? S_PAUSE : S_F0;
                    else        w_ntstep = r_tstep + 3'd1;
                end
                S_PAUSE: if (!Stop && (!StepEn || Step)) w_nstate = S_F0;
                S_HALT:  w_nstate = S_HALT;
                default: w_nstate = S_RST;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_RST;
            r_tstep  <= 3'd0;
            r_cls    <= CL_NOP;
            r_wcnt   <= '0;
            r_buserr <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_tstep <= w_ntstep;
            r_wcnt  <= w_nwcnt;
            if (r_state == S_DEC) r_cls    <= w_dcls;
            if (w_timeout)        r_buserr <= 1'b1;
        end
    end

    // Moore strobe decode from {state, class, tstep}
    always_comb begin
        Ctrl = '0;
        case (r_state)
            S_F0: Ctrl = cbit(C_PCOUT) | cbit(C_MARIN);
            S_F1: Ctrl = cbit(C_MEMRD) | cbit(C_MDRIN);
            S_F2: Ctrl = cbit(C_MDROUT) | cbit(C_IRIN) | cbit(C_INCPC) | cbit(C_PCIN);
            S_EXEC: begin
                case (r_cls)
                    CL_ALU, CL_IMM, CL_MULDIV: begin
                        case (r_tstep)
                            3'd3: Ctrl = cbit(C_GRB) | cbit(C_ROUT) | cbit(C_YIN);
                            3'd4: Ctrl = cbit(C_ZHIN) | cbit(C_ZLIN) |
                                         ((r_cls == CL_IMM) ? cbit(C_COUT) : (cbit(C_GRC) | cbit(C_ROUT)));
                            3'd5: Ctrl = (r_cls == CL_MULDIV) ? (cbit(C_ZLOUT) | cbit(C_LOIN))
                                                              : (cbit(C_ZLOUT) | cbit(C_GRA) | cbit(C_RIN));
                            3'd6: Ctrl = cbit(C_ZHOUT) | cbit(C_HIIN);
                            default: Ctrl = '0;
                        endcase
                    end
                    CL_UNARY: begin
                        if (r_tstep == 3'd3) Ctrl = cbit(C_GRB) | cbit(C_ROUT) | cbit(C_ZHIN) | cbit(C_ZLIN);
                        else                 Ctrl = cbit(C_ZLOUT) | cbit(C_GRA) | cbit(C_RIN);
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        case (r_tstep)
                            3'd3: Ctrl = cbit(C_GRB) | cbit(C_BAOUT) | cbit(C_YIN);
                            3'd4: Ctrl = cbit(C_COUT) | cbit(C_ZHIN) | cbit(C_ZLIN);
                            3'd5: Ctrl = (r_cls == CL_LDI) ? (cbit(C_ZLOUT) | cbit(C_GRA) | cbit(C_RIN))
                                                           : (cbit(C_ZLOUT) | cbit(C_MARIN));
                            3'd6: Ctrl = (r_cls == CL_ST) ? (cbit(C_GRA) | cbit(C_ROUT) | cbit(C_MDRIN))
                                                          : (cbit(C_MEMRD) | cbit(C_MDRIN));
                            3'd7: Ctrl = (r_cls == CL_ST) ? cbit(C_MEMWR)
                                                          : (cbit(C_MDROUT) | cbit(C_GRA) | cbit(C_RIN));
                            default: Ctrl = '0;
                        endcase
                    end
                    CL_BR: begin
                        case (r_tstep)
                            3'd3: Ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_CONIN);
                            3'd4: Ctrl = cbit(C_PCOUT) | cbit(C_YIN);
                            3'd5: Ctrl = cbit(C_COUT) | cbit(C_ZHIN) | cbit(C_ZLIN);
                            3'd6: Ctrl = cbit(C_ZLOUT) | cbit(C_PCINCOND);
                            default: Ctrl = '0;
                        endcase
                    end
                    CL_JR:   Ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_PCIN);
                    CL_JAL:  Ctrl = (r_tstep == 3'd3) ? cbit(C_PCOUT)
                                                      : (cbit(C_GRA) | cbit(C_ROUT) | cbit(C_PCIN));
                    CL_MFHI: Ctrl = cbit(C_HIOUT) | cbit(C_GRA) | cbit(C_RIN);
                    CL_MFLO: Ctrl = cbit(C_LOOUT) | cbit(C_GRA) | cbit(C_RIN);
                    CL_IN:   Ctrl = cbit(C_INPORTOUT) | cbit(C_GRA) | cbit(C_RIN);
                    CL_OUT:  Ctrl = cbit(C_GRA) | cbit(C_ROUT) | cbit(C_OUTPORTIN);
                    default: Ctrl = '0;
                endcase
            end
            default: Ctrl = '0;
        endcase
    end

    assign R_enableIn = (r_state == S_EXEC && r_cls == CL_JAL && r_tstep == 3'd3) ? LINK_MASK : '0;
    assign Run        = (r_state != S_PAUSE) && (r_state != S_HALT);
    assign Halted     = (r_state == S_HALT);
    assign BusErr     = r_buserr;
    assign IllegalOp  = (r_state == S_DEC) && !w_legal;
    // Wait counter is still zero only on the first cycle of a held final step
    assign InstrDone  = w_last && (r_wcnt == '0);

endmodule

// File: tb/tb_ctrl_seq_param.sv
// tb/tb_ctrl_seq_param.sv - randomized self-checking bench for ctrl_seq_param
module tb_ctrl_seq_param;
    import ctrl_seq_pkg::*;

    localparam int TO = 8;

    logic            Clock = 1'b0;
    logic            Reset, MemAck, Stop, StepEn, Step;
    logic [31:0]     IR;
    logic [CW-1:0]   Ctrl;
    logic [15:0]     R_enableIn;
    logic            Run, Halted, BusErr, IllegalOp, InstrDone;

    ctrl_seq_param #(.OPW(5), .NREG(16), .LINK_REG(15), .MEM_TO(TO)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MemAck(MemAck), .Stop(Stop),
        .StepEn(StepEn), .Step(Step), .Ctrl(Ctrl), .R_enableIn(R_enableIn),
        .Run(Run), .Halted(Halted), .BusErr(BusErr), .IllegalOp(IllegalOp),
        .InstrDone(InstrDone)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [15:0]   ren;
        logic          run, halted, berr, done, ill;
    } out_t;

    typedef struct {
        out_t        o;
        logic        ack_care, ack, stop, stepen, step;
        logic [31:0] ir;
    } cyc_t;

    int            checks = 0;
    int            errors = 0;
    cyc_t          q[$];
    out_t          obs_q[$];
    out_t          exp_q[$];
    logic [CW-1:0] sq[$];
    int            sw;
    logic [31:0]   cur_ir = '0;
    logic          cur_stepen = 1'b0;

    function automatic logic [CW-1:0] b(input int i);
        logic [CW-1:0] one = 1;
        return one << i;
    endfunction

    function automatic cyc_t mk(input logic [CW-1:0] c);
        cyc_t e;
        e.o = '0; e.o.ctrl = c; e.o.run = 1'b1;
        e.ack_care = 1'b0; e.ack = 1'b0; e.stop = 1'b0; e.step = 1'b0;
        e.stepen = cur_stepen; e.ir = cur_ir;
        return e;
    endfunction

    // Step strobe lists straight from the instruction descriptions; sw marks the memory-wait step
    task automatic get_steps(input logic [4:0] op);
        logic [CW-1:0] a3, cz, wr, l3, z;
        a3 = b(C_GRB) | b(C_ROUT) | b(C_YIN);
        cz = b(C_COUT) | b(C_ZHIN) | b(C_ZLIN);
        wr = b(C_ZLOUT) | b(C_GRA) | b(C_RIN);
        l3 = b(C_GRB) | b(C_BAOUT) | b(C_YIN);
        z  = '0;
        sw = -1;
        sq.delete();
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ROL, OP_ROR:
                sq = '{a3, b(C_GRC) | b(C_ROUT) | b(C_ZHIN) | b(C_ZLIN), wr};
            OP_ADDI, OP_ANDI, OP_ORI: sq = '{a3, cz, wr};
            OP_MUL, OP_DIV:
                sq = '{a3, b(C_GRC) | b(C_ROUT) | b(C_ZHIN) | b(C_ZLIN),
                       b(C_ZLOUT) | b(C_LOIN), b(C_ZHOUT) | b(C_HIIN)};
            OP_NEG, OP_NOT: sq = '{b(C_GRB) | b(C_ROUT) | b(C_ZHIN) | b(C_ZLIN), wr};
            OP_LD: begin
                sq = '{l3, cz, b(C_ZLOUT) | b(C_MARIN), b(C_MEMRD) | b(C_MDRIN),
                       b(C_MDROUT) | b(C_GRA) | b(C_RIN)};
                sw = 3;
            end
            OP_LDI: sq = '{l3, cz, wr};
            OP_ST: begin
                sq = '{l3, cz, b(C_ZLOUT) | b(C_MARIN), b(C_GRA) | b(C_ROUT) | b(C_MDRIN), b(C_MEMWR)};
                sw = 4;
            end
            OP_BR: sq = '{b(C_GRA) | b(C_ROUT) | b(C_CONIN), b(C_PCOUT) | b(C_YIN), cz,
                          b(C_ZLOUT) | b(C_PCINCOND)};
            OP_JR:   sq = '{b(C_GRA) | b(C_ROUT) | b(C_PCIN)};
            OP_JAL:  sq = '{b(C_PCOUT), b(C_GRA) | b(C_ROUT) | b(C_PCIN)};
            OP_MFHI: sq = '{b(C_HIOUT) | b(C_GRA) | b(C_RIN)};
            OP_MFLO: sq = '{b(C_LOOUT) | b(C_GRA) | b(C_RIN)};
            OP_IN:   sq = '{b(C_INPORTOUT) | b(C_GRA) | b(C_RIN)};
            OP_OUT:  sq = '{b(C_GRA) | b(C_ROUT) | b(C_OUTPORTIN)};
            OP_NOP:  sq = '{z};
            default: sq.delete();
        endcase
    endtask

    // A wait step lasts d+1 cycles, MemAck arriving on the last of them
    task automatic push_wait(input logic [CW-1:0] c, input int d, input logic last);
        cyc_t e;
        for (int k = 0; k <= d; k++) begin
            e = mk(c);
            e.ack_care = 1'b1;
            e.ack = (k == d);
            e.o.done = last && (k == 0);
            q.push_back(e);
        end
    endtask

    task automatic build(input logic [4:0] op, input int df, input int dw);
        cyc_t e;
        logic last;
        cur_ir = {op, 27'($urandom)};
        q.push_back(mk(b(C_PCOUT) | b(C_MARIN)));
        push_wait(b(C_MEMRD) | b(C_MDRIN), df, 1'b0);
        q.push_back(mk(b(C_MDROUT) | b(C_IRIN) | b(C_INCPC) | b(C_PCIN)));
        e = mk('0);
        e.o.ill = (op > 5'd26);
        q.push_back(e);
        if (op == OP_HALT) begin
            for (int k = 0; k < 3; k++) begin
                e = mk('0); e.o.run = 1'b0; e.o.halted = 1'b1; e.stop = 1'($urandom);
                q.push_back(e);
            end
        end else begin
            get_steps(op);
            for (int i = 0; i < sq.size(); i++) begin
                last = (i == sq.size() - 1);
                if (i == sw) push_wait(sq[i], dw, last);
                else begin
                    e = mk(sq[i]);
                    e.o.done = last;
                    if (op == OP_JAL && i == 0) e.o.ren = 16'h8000;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic push_pause(input logic stop, input logic step);
        cyc_t e;
        e = mk('0); e.o.run = 1'b0; e.stop = stop; e.step = step;
        q.push_back(e);
    endtask

    // Drives one cycle per queued entry and records observed vs modelled outputs
    task automatic drive_cycles();
        cyc_t e;
        out_t ob;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge Clock);
            ob = {Ctrl, R_enableIn, Run, Halted, BusErr, InstrDone, IllegalOp};
            obs_q.push_back(ob);
            exp_q.push_back(e.o);
            MemAck = e.ack_care ? e.ack : 1'($urandom);
            Stop = e.stop; StepEn = e.stepen; Step = e.step; IR = e.ir;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; Stop = 1'b0; StepEn = 1'b0; Step = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; MemAck = 1'b0; Stop = 1'b0; StepEn = 1'b0; Step = 1'b0; IR = '0;
        @(negedge Clock); @(negedge Clock);
        checks++; if (Ctrl !== '0)        begin errors++; $display("FAIL reset_ctrl got %h want 0", Ctrl); end
        checks++; if (R_enableIn !== '0)  begin errors++; $display("FAIL reset_ren got %h want 0", R_enableIn); end
        checks++; if (Run !== 1'b1)       begin errors++; $display("FAIL reset_run got %b want 1", Run); end
        checks++; if ({Halted, BusErr, IllegalOp, InstrDone} !== 4'b0)
            begin errors++; $display("FAIL reset_flags got %b want 0000", {Halted, BusErr, IllegalOp, InstrDone}); end
        Reset = 1'b0;
    endtask

    task automatic test_add();
        cur_stepen = 1'b0;
        do_reset();
        build(OP_ADD, 0, 0);
        q[0].ir = 32'h19A20000;
        for (int i = 0; i < q.size(); i++) q[i].ir = 32'h19A20000;
        build(OP_ADD, 0, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL add cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_ld_wait();
        do_reset();
        build(OP_LD, 0, 3);
        build(OP_ST, 2, 1);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ld_wait cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        cyc_t e;
        do_reset();
        cur_ir = {OP_ADD, 27'd0};
        q.push_back(mk(b(C_PCOUT) | b(C_MARIN)));
        for (int k = 0; k < TO; k++) begin
            e = mk(b(C_MEMRD) | b(C_MDRIN)); e.ack_care = 1'b1; e.ack = 1'b0;
            q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            e = mk('0); e.o.run = 1'b0; e.o.halted = 1'b1; e.o.berr = 1'b1;
            e.stop = 1'($urandom); e.step = 1'($urandom);
            q.push_back(e);
        end
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        Reset = 1'b1;
        #1;
        checks++; if ({BusErr, Halted, Run} !== 3'b001)
            begin errors++; $display("FAIL timeout_clear got %b want 001", {BusErr, Halted, Run}); end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_jal();
        do_reset();
        build(OP_JAL, 0, 0);
        build(OP_JAL, 1, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL jal cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_stop();
        cyc_t e, e2;
        do_reset();
        build(OP_ADD, 0, 0);
        e = q.pop_back(); e2 = q.pop_back();
        e.stop = 1'b1; e2.stop = 1'b1;
        q.push_back(e2); q.push_back(e);
        for (int k = 0; k < 3; k++) push_pause(1'b1, 1'($urandom));
        push_pause(1'b0, 1'b0);
        build(OP_OR, 0, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stop cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_step();
        do_reset();
        cur_stepen = 1'b1;
        for (int n = 0; n < 3; n++) begin
            build(5'($urandom_range(0, 25)), $urandom_range(0, 2), $urandom_range(0, 2));
            for (int k = 0; k < $urandom_range(0, 3); k++) push_pause(1'b0, 1'b0);
            push_pause(1'b1, 1'b1);
            push_pause(1'b0, 1'b1);
        end
        cur_stepen = 1'b0;
        build(OP_NOP, 0, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL step cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal_halt();
        do_reset();
        build(5'b11111, 0, 0);
        build(5'($urandom_range(27, 31)), 1, 0);
        build(OP_ADD, 0, 0);
        build(OP_HALT, 0, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL illegal cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        build(OP_LD, 0, 5);
        while (q.size() > 8) void'(q.pop_back());   // stop at the first cycle of T6
        drive_cycles();
        Reset = 1'b1;
        #1;
        checks++; if (Ctrl !== '0) begin errors++; $display("FAIL reset_mid_ctrl got %h want 0", Ctrl); end
        checks++; if (Run !== 1'b1) begin errors++; $display("FAIL reset_mid_run got %b want 1", Run); end
        @(negedge Clock);
        Reset = 1'b0;
        build(OP_ADD, 0, 0);
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == OP_HALT) op = OP_NOP;
            build(op, $urandom_range(0, TO - 2), $urandom_range(0, TO - 2));
        end
        drive_cycles();
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_timeout();
        test_jal();
        test_stop();
        test_step();
        test_illegal_halt();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
